// File: rtl/npc_pkg.sv
// Shared fetch-side definitions: IFU state encoding, datapath width and reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package npc_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_DLV  = 3'd2,
    S_NPC  = 3'd3,
    S_HALT = 3'd4
  } ifu_state_t;

endpackage

// File: rtl/ifu_pc_reg.sv
// Architectural PC register with synchronous reset to RESET_PC and a load enable.
// Latency: loaded value visible the cycle after i_load.
// Backpressure: none; reset has priority over load.
module ifu_pc_reg import npc_pkg::*; #(
  parameter int              XLEN     = npc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_d,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN-1:0] r_pc;

  // PC holds unless reset or an accepted next-PC loads it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_d;
    end
  end

  assign o_q = r_pc;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: one imem read per instruction, hand word+PC to decode, then wait for next PC.
// Latency: minimum 4 cycles per instruction (REQ, WAIT>=1, DLV, NPC).
// Backpressure: holds request/addr until imem ready, holds inst/inst_pc until decode ready.
// Optional IFU_MISALIGN_TRAP_EN: adds misalign output and halts on a next PC with npc[1:0]!=0.
module ifu_fetch import npc_pkg::*; #(
  parameter logic [31:0] RESET_PC = npc_pkg::RESET_PC,
  parameter int          XLEN     = npc_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            npc_ready,
  input  logic            npc_valid,
  input  logic [XLEN-1:0] npc,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic            misalign,
`endif
  output logic [XLEN-1:0] pc
);

  ifu_state_t      r_state;
  ifu_state_t      w_next;
  logic            w_req_vld;
  logic            w_inst_vld;
  logic            w_npc_rdy;
  logic            w_pc_load;
  logic            w_inst_latch;
  logic            w_trap;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;

  ifu_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC[XLEN-1:0])
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_pc_load),
    .i_d    (npc),
    .o_q    (w_pc)
  );

  // State register; reset always lands in S_REQ regardless of handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state channel strobes
  always_comb begin
    w_next       = r_state;
    w_req_vld    = 1'b0;
    w_inst_vld   = 1'b0;
    w_npc_rdy    = 1'b0;
    w_pc_load    = 1'b0;
    w_inst_latch = 1'b0;
    w_trap       = 1'b0;
    case (r_state)
      S_REQ: begin
        w_req_vld = 1'b1;
        if (imem_req_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          w_inst_latch = 1'b1;
          w_next       = S_DLV;
        end
      end
      S_DLV: begin
        w_inst_vld = 1'b1;
        if (inst_ready) w_next = S_NPC;
      end
      S_NPC: begin
        w_npc_rdy = 1'b1;
        if (npc_valid) begin
          w_pc_load = 1'b1;
          w_next    = S_REQ;
`ifdef IFU_MISALIGN_TRAP_EN
          // Misaligned target is still recorded in pc for the trap handler to see
          if (npc[1:0] != 2'b00) begin
            w_trap = 1'b1;
            w_next = S_HALT;
          end
`endif
        end
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_REQ;
      end
    endcase
  end

  // Captured instruction word and its PC, held stable until the next response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst    <= '0;
      r_inst_pc <= '0;
    end else if (w_inst_latch) begin
      r_inst    <= imem_rsp_data;
      r_inst_pc <= w_pc;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  logic r_misalign;

  // Sticky trap flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_trap) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign = r_misalign;
`endif

  // Valids are masked during reset so nothing is offered on the reset cycle
  assign imem_req_valid = w_req_vld  & ~rst;
  assign inst_valid     = w_inst_vld & ~rst;
  assign npc_ready      = w_npc_rdy  & ~rst;
  assign imem_addr      = w_pc;
  assign pc             = w_pc;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: vector table for reset/loop/jump, hand sequences for corner cases.
// Latency: n/a.
// Backpressure: exercised on both request and decode channels.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        npc_ready;
  logic        npc_valid;
  logic [31:0] npc;
  logic [31:0] pc;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .npc_ready      (npc_ready),
    .npc_valid      (npc_valid),
    .npc            (npc),
`ifdef IFU_MISALIGN_TRAP_EN
    .misalign       (misalign),
`endif
    .pc             (pc)
  );

  always #5 clk = ~clk;

  // Count accepted fetch requests to detect duplicates
  always @(posedge clk) begin
    if (imem_req_valid && imem_req_ready) hs_cnt <= hs_cnt + 1;
  end

  typedef struct {
    logic        rst;
    logic        req_rdy;
    logic        rsp_vld;
    logic [31:0] rsp_dat;
    logic        inst_rdy;
    logic        npc_vld;
    logic [31:0] npc_dat;
    logic        e_req_vld;
    logic        e_inst_vld;
    logic [31:0] e_inst;
    logic [31:0] e_inst_pc;
    logic        e_npc_rdy;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then move to the sampling point (falling edge)
  task automatic apply(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic nv, input logic [31:0] n);
    rst            = r;
    imem_req_ready = rr;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    inst_ready     = ir;
    npc_valid      = nv;
    npc            = n;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] held_addr;
  int          hs_before;

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; npc_valid = 1'b0; npc = '0;

    //              rst rr rv rsp_dat       ir nv npc            req iv inst          inst_pc       nr pc
    vecs[0] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h8000_0000};
    vecs[1] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        32'h0,        1'b0,32'h8000_0000};
    vecs[2] = '{1'b0,1'b0,1'b1,32'h0010_0093,1'b0,1'b1,32'hDEAD_BEEC,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h8000_0000};
    vecs[3] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b1,32'h0010_0093,32'h8000_0000,1'b0,32'h8000_0000};
    vecs[4] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h8000_0004,1'b0,1'b0,32'h0010_0093,32'h8000_0000,1'b1,32'h8000_0000};
    vecs[5] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0010_0093,32'h8000_0000,1'b0,32'h8000_0004};
    vecs[6] = '{1'b0,1'b0,1'b1,32'h0000_0013,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0010_0093,32'h8000_0000,1'b0,32'h8000_0004};
    vecs[7] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b1,32'h0000_0013,32'h8000_0004,1'b0,32'h8000_0004};
    vecs[8] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h8000_0100,1'b0,1'b0,32'h0000_0013,32'h8000_0004,1'b1,32'h8000_0004};
    vecs[9] = '{1'b0,1'b0,1'b1,32'hFFFF_FFFF,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0000_0013,32'h8000_0004,1'b0,32'h8000_0100};

    // First reset cycle: state is unknown until the first edge
    adv();

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].rst, vecs[i].req_rdy, vecs[i].rsp_vld, vecs[i].rsp_dat,
            vecs[i].inst_rdy, vecs[i].npc_vld, vecs[i].npc_dat);
      chk($sformatf("v%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_req_vld));
      chk($sformatf("v%0d addr", i),      imem_addr,           vecs[i].e_pc);
      chk($sformatf("v%0d inst_valid", i), 32'(inst_valid),    32'(vecs[i].e_inst_vld));
      chk($sformatf("v%0d inst", i),      inst,                vecs[i].e_inst);
      chk($sformatf("v%0d inst_pc", i),   inst_pc,             vecs[i].e_inst_pc);
      chk($sformatf("v%0d npc_ready", i), 32'(npc_ready),      32'(vecs[i].e_npc_rdy));
      chk($sformatf("v%0d pc", i),        pc,                  vecs[i].e_pc);
      adv();
    end

    // Request backpressure: three more stalled cycles at 0x8000_0100
    hs_before = hs_cnt;
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("bp req_valid held", 32'(imem_req_valid), 32'd1);
      chk("bp addr held", imem_addr, 32'h8000_0100);
      adv();
    end
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    adv();
    // Memory slow; ready stays high but no second request may be issued
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("wait req_valid low", 32'(imem_req_valid), 32'd0);
      adv();
    end
    chk("single request", 32'(hs_cnt - hs_before), 32'd1);
    apply(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    adv();
    // Decode backpressure for five cycles
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 1'b0, 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 32'h0);
      chk("dlv inst_valid", 32'(inst_valid), 32'd1);
      chk("dlv inst held", inst, 32'h1234_5678);
      chk("dlv inst_pc held", inst_pc, 32'h8000_0100);
      adv();
    end
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    adv();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0104);
    adv();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("after bp addr", imem_addr, 32'h8000_0104);
    chk("after bp req_valid", 32'(imem_req_valid), 32'd1);

    // Reset while delivering to decode
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    adv();
    apply(1'b0, 1'b0, 1'b1, 32'h5555_0000, 1'b0, 1'b0, 32'h0);
    adv();
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("rst in dlv inst_valid", 32'(inst_valid), 32'd0);
    adv();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("post rst inst_valid", 32'(inst_valid), 32'd0);
    chk("post rst pc", pc, 32'h8000_0000);
    chk("post rst req_valid", 32'(imem_req_valid), 32'd1);
    chk("post rst addr", imem_addr, 32'h8000_0000);
    chk("post rst inst", inst, 32'h0);

    // Misaligned next PC
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    adv();
    apply(1'b0, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    adv();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    adv();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0006);
    chk("mis npc_ready", 32'(npc_ready), 32'd1);
    adv();
    held_addr = 32'h8000_0006;
`ifdef IFU_MISALIGN_TRAP_EN
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h8000_0008);
      chk("halt misalign", 32'(misalign), 32'd1);
      chk("halt req_valid", 32'(imem_req_valid), 32'd0);
      chk("halt npc_ready", 32'(npc_ready), 32'd0);
      chk("halt pc", pc, held_addr);
      adv();
    end
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    adv();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("trap cleared", 32'(misalign), 32'd0);
    chk("trap rst req_valid", 32'(imem_req_valid), 32'd1);
    chk("trap rst addr", imem_addr, 32'h8000_0000);
`else
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("misaligned req_valid", 32'(imem_req_valid), 32'd1);
    chk("misaligned addr", imem_addr, held_addr);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
